// File: rtl/seq_pkg.sv
// Shared encodings and constants for the serial pattern transmitter (seq_gen).
package seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_SHIFT = 4'b0010,
    ST_GAP   = 4'b0100,
    ST_DONE  = 4'b1000
  } seq_state_e;

  // Pattern the downstream sequence detector is built to recognise.
  localparam logic [3:0] SEQ_PAT_DEFAULT = 4'b0101;
  localparam logic       SEQ_IDLE_VAL    = 1'b1;

endpackage

// File: rtl/seq_shreg.sv
// Load/rotate pattern register: keeps the latched pattern and a working copy
// that rotates left one bit per transmitted bit and reloads at each repetition.
module seq_shreg #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             reload,
  input  logic             rot,
  input  logic [PAT_W-1:0] pat_in,
  output logic             nxt_bit,
  output logic             pat_msb
);

  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] sh_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= '0;
      sh_q  <= '0;
    end else if (load) begin
      pat_q <= pat_in;
      sh_q  <= pat_in;
    end else if (reload) begin
      sh_q  <= pat_q;
    end else if (rot) begin
      sh_q  <= {sh_q[PAT_W-2:0], sh_q[PAT_W-1]};
    end
  end

  // sh_q MSB is the bit currently on the line, so the bit after it sits one below.
  assign nxt_bit = sh_q[PAT_W-2];
  assign pat_msb = pat_q[PAT_W-1];

endmodule

// File: rtl/seq_gen.sv
// Serial test-pattern transmitter, MSB first, repeated reps times.
// Define SEQ_GEN_GAP_EN to insert GAP_CYC idle cycles between repetitions.
module seq_gen
  import seq_pkg::*;
#(
  parameter int   PAT_W    = 4,
  parameter int   CNT_W    = 8,
  parameter logic IDLE_VAL = SEQ_IDLE_VAL,
  parameter int   GAP_CYC  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  output logic             dout,
  output logic             dout_vld,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = $clog2(PAT_W);

  if (PAT_W < 2 || GAP_CYC < 1) begin : g_param_chk
    $error("seq_gen: PAT_W must be >= 2 and GAP_CYC >= 1");
  end

  seq_state_e       state_q, state_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             load, reload, rot;
  logic             nxt_bit, pat_msb;
  logic             dout_d, vld_d, busy_d, done_d;
`ifdef SEQ_GEN_GAP_EN
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  logic [GAP_W-1:0] gap_q, gap_d;
`endif

  seq_shreg #(.PAT_W(PAT_W)) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .reload  (reload),
    .rot     (rot),
    .pat_in  (pattern),
    .nxt_bit (nxt_bit),
    .pat_msb (pat_msb)
  );

  // Output values are computed for the next cycle so every output is a flop.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    load    = 1'b0;
    reload  = 1'b0;
    rot     = 1'b0;
    dout_d  = IDLE_VAL;
    vld_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SEQ_GEN_GAP_EN
    gap_d   = gap_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load  = 1'b1;
          rep_d = reps;
          bit_d = '0;
          if (reps == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SHIFT;
            dout_d  = pattern[PAT_W-1];
            vld_d   = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        busy_d = 1'b1;
        if (bit_q == BIT_W'(PAT_W - 1)) begin
          bit_d = '0;
          rep_d = rep_q - 1'b1;
          if (rep_q == CNT_W'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
`ifdef SEQ_GEN_GAP_EN
            state_d = ST_GAP;
            gap_d   = '0;
`else
            reload  = 1'b1;
            dout_d  = pat_msb;
            vld_d   = 1'b1;
`endif
          end
        end else begin
          bit_d  = bit_q + 1'b1;
          rot    = 1'b1;
          dout_d = nxt_bit;
          vld_d  = 1'b1;
        end
      end
`ifdef SEQ_GEN_GAP_EN
      ST_GAP: begin
        busy_d = 1'b1;
        if (gap_q == GAP_W'(GAP_CYC - 1)) begin
          state_d = ST_SHIFT;
          reload  = 1'b1;
          dout_d  = pat_msb;
          vld_d   = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bit_q    <= '0;
      rep_q    <= '0;
      dout     <= IDLE_VAL;
      dout_vld <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      rep_q    <= rep_d;
      dout     <= dout_d;
      dout_vld <= vld_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

`ifdef SEQ_GEN_GAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) gap_q <= '0;
    else     gap_q <= gap_d;
  end
`endif

endmodule
